// File: rtl/huffman_packer_pkg.sv
// Shared constants, packer state encoding and mask length helper
// for the Huffman code packer.
package huffman_packer_pkg;

    localparam int NSYM = 6;
    localparam int CW   = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        FLUSH,
        DONE
    } state_t;

    function automatic logic [3:0] mask_len(input logic [CW-1:0] mask);
        logic [3:0] len;
        len = 4'd0;
        for (int i = 0; i < CW; i++) begin
            if (mask[i]) len = 4'(i + 1);
        end
        return len;
    endfunction

endpackage

// File: rtl/huffman_code_table.sv
// Latches the six code words and their lengths on load and
// looks up code/length for a symbol, flagging illegal symbols.
module huffman_code_table
    import huffman_packer_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [NSYM*CW-1:0] hc_bus,
    input  logic [NSYM*CW-1:0] m_bus,
    input  logic [7:0]         sym,
    output logic [CW-1:0]      code,
    output logic [3:0]         len,
    output logic               illegal
);

    logic [CW-1:0] code_r [NSYM];
    logic [3:0]    len_r  [NSYM];
    logic [2:0]    idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NSYM; i++) begin
                code_r[i] <= '0;
                len_r[i]  <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < NSYM; i++) begin
                code_r[i] <= hc_bus[i*CW +: CW] & m_bus[i*CW +: CW];
                len_r[i]  <= mask_len(m_bus[i*CW +: CW]);
            end
        end
    end

    assign idx = 3'(sym - 8'd1);

    always_comb begin
        code    = '0;
        len     = '0;
        illegal = 1'b1;
        if (sym >= 8'd1 && sym <= 8'(NSYM)) begin
            code    = code_r[idx];
            len     = len_r[idx];
            illegal = (len_r[idx] == 4'd0);
        end
    end

endmodule

// File: rtl/huffman_packer.sv
// Packs Huffman codes for a gray symbol stream into MSB-first bytes,
// zero-padding and marking the final byte on flush.
module huffman_packer
    import huffman_packer_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          code_valid,
    input  logic [CW-1:0] HC1,
    input  logic [CW-1:0] HC2,
    input  logic [CW-1:0] HC3,
    input  logic [CW-1:0] HC4,
    input  logic [CW-1:0] HC5,
    input  logic [CW-1:0] HC6,
    input  logic [CW-1:0] M1,
    input  logic [CW-1:0] M2,
    input  logic [CW-1:0] M3,
    input  logic [CW-1:0] M4,
    input  logic [CW-1:0] M5,
    input  logic [CW-1:0] M6,
    input  logic          sym_valid,
    input  logic [7:0]    sym_data,
    output logic          sym_ready,
    input  logic          flush,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_last,
    output logic [15:0]   byte_cnt,
    output logic          sym_err
);

    state_t        state, state_nx;
    logic [15:0]   acc;
    logic [4:0]    cnt;
    logic          flush_pending;
    logic          take, accept, emit, pad, last_nx;
    logic [7:0]    byte_nx;
    logic [CW-1:0] code;
    logic [3:0]    len;
    logic          illegal;

    huffman_code_table u_table (
        .clk     (clk),
        .reset   (reset),
        .load    (take),
        .hc_bus  ({HC6, HC5, HC4, HC3, HC2, HC1}),
        .m_bus   ({M6, M5, M4, M3, M2, M1}),
        .sym     (sym_data),
        .code    (code),
        .len     (len),
        .illegal (illegal)
    );

    assign take      = code_valid && (state == IDLE || state == DONE);
    assign sym_ready = (state == RUN) && (cnt < 5'd8) && !flush_pending;
    assign accept    = sym_valid && sym_ready;

    // A full byte seen together with flush is held for FLUSH so it
    // can still carry out_last when nothing follows it.
    always_comb begin
        state_nx = state;
        emit     = 1'b0;
        pad      = 1'b0;
        last_nx  = 1'b0;
        byte_nx  = 8'(acc >> (cnt - 5'd8));
        unique case (state)
            IDLE, DONE: if (take) state_nx = LOAD;
            LOAD:       state_nx = RUN;
            RUN: begin
                if (flush) state_nx = FLUSH;
                else       emit = (cnt >= 5'd8);
            end
            FLUSH: begin
                if (cnt >= 5'd8) begin
                    emit    = 1'b1;
                    last_nx = (cnt == 5'd8);
                    if (cnt == 5'd8) state_nx = DONE;
                end else begin
                    state_nx = DONE;
                    if (cnt != 5'd0) begin
                        emit    = 1'b1;
                        pad     = 1'b1;
                        last_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        if (pad) byte_nx = 8'(acc << (5'd8 - cnt));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            acc           <= '0;
            cnt           <= '0;
            flush_pending <= 1'b0;
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_last      <= 1'b0;
            byte_cnt      <= '0;
            sym_err       <= 1'b0;
        end else begin
            state     <= state_nx;
            out_valid <= emit;
            out_last  <= last_nx;
            if (emit) begin
                out_data <= byte_nx;
                byte_cnt <= byte_cnt + 16'd1;
                cnt      <= pad ? 5'd0 : cnt - 5'd8;
            end
            if (accept) begin
                if (illegal) begin
                    sym_err <= 1'b1;
                end else begin
                    acc <= (acc << len) | 16'(code);
                    cnt <= cnt + 5'(len);
                end
            end
            if (state == RUN && flush) flush_pending <= 1'b1;
            if (state == LOAD) begin
                acc           <= '0;
                cnt           <= '0;
                flush_pending <= 1'b0;
                byte_cnt      <= '0;
                sym_err       <= 1'b0;
            end
        end
    end

endmodule
